// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational Hack ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARBITER_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int W       = 16,
  parameter int ALU_LAT = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [2*W-1:0] req_x,
  input  logic [2*W-1:0] req_y,
  input  logic [11:0]    req_ctrl,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [W-1:0]   rsp_data,
  output logic           rsp_zr,
  output logic           rsp_ng,
  output logic [W-1:0]   alu_x,
  output logic [W-1:0]   alu_y,
  output logic [5:0]     alu_ctrl,
  input  logic [W-1:0]   alu_out,
  input  logic           alu_zr,
  input  logic           alu_ng,
  output logic           busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t       state_reg, state_next;
  logic [3:0]   cnt_reg, cnt_next;
  logic         grant_reg;
  logic         grant_sel;
  logic         any_req;
  logic         exec_done;
  logic [W-1:0] x_reg, y_reg;
  logic [5:0]   ctrl_reg;
  logic [W-1:0] rsp_data_reg;
  logic         rsp_zr_reg, rsp_ng_reg;

  logic [W-1:0] x_arr [2];
  logic [W-1:0] y_arr [2];
  logic [5:0]   ctrl_arr [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign x_arr[gi]    = req_x[gi*W +: W];
      assign y_arr[gi]    = req_y[gi*W +: W];
      assign ctrl_arr[gi] = req_ctrl[gi*6 +: 6];
    end
  endgenerate

  assign any_req   = |req_valid;
  assign exec_done = (cnt_reg == 4'(ALU_LAT - 1));

`ifdef ALU_ARBITER_RR_EN
  // Pointer names the requester that wins a tie; it moves away from every winner.
  logic ptr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= 1'b0;
    end else if (state_reg == IDLE && any_req) begin
      ptr_reg <= ~grant_sel;
    end
  end

  always_comb begin
    grant_sel = ~req_valid[0];
    if (&req_valid) begin
      grant_sel = ptr_reg;
    end
  end
`else
  assign grant_sel = ~req_valid[0];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg      <= 4'd0;
      grant_reg    <= 1'b0;
      x_reg        <= '0;
      y_reg        <= '0;
      ctrl_reg     <= 6'd0;
      rsp_data_reg <= '0;
      rsp_zr_reg   <= 1'b0;
      rsp_ng_reg   <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      if (state_reg == IDLE && any_req) begin
        grant_reg <= grant_sel;
        x_reg     <= x_arr[grant_sel];
        y_reg     <= y_arr[grant_sel];
        ctrl_reg  <= ctrl_arr[grant_sel];
      end
      if (state_reg == EXEC && exec_done) begin
        rsp_data_reg <= alu_out;
        rsp_zr_reg   <= alu_zr;
        rsp_ng_reg   <= alu_ng;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = 4'd0;
    unique case (state_reg)
      IDLE: if (any_req) state_next = EXEC;
      EXEC: begin
        if (exec_done) state_next = RESP;
        else           cnt_next   = cnt_reg + 4'd1;
      end
      RESP: if (rsp_ready[grant_reg]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // req_ready is masked by reset so the strobe drops the instant reset rises.
  always_comb begin
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    busy      = 1'b1;
    case (state_reg)
      IDLE: begin
        busy = 1'b0;
        if (any_req && !reset) req_ready[grant_sel] = 1'b1;
      end
      RESP:    rsp_valid[grant_reg] = 1'b1;
      default: ;
    endcase
  end

  assign alu_x    = x_reg;
  assign alu_y    = y_reg;
  assign alu_ctrl = ctrl_reg;
  assign rsp_data = rsp_data_reg;
  assign rsp_zr   = rsp_zr_reg;
  assign rsp_ng   = rsp_ng_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: three instances (ALU_LAT 1, 3, 4), each with its own behavioural Hack ALU.
// Directed vector table, multi-cycle corner sequences, then randomized traffic against a transaction model.
module tb_alu_arbiter;
  localparam int W  = 16;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [1:0]     req_valid_a [NI];
  logic [1:0]     rsp_ready_a [NI];
  logic [2*W-1:0] req_x, req_y;
  logic [11:0]    req_ctrl;
  logic [1:0]     req_ready_a [NI];
  logic [1:0]     rsp_valid_a [NI];
  logic [W-1:0]   rsp_data_a [NI];
  logic           rsp_zr_a [NI];
  logic           rsp_ng_a [NI];
  logic           busy_a [NI];
  logic [W-1:0]   alu_x_a [NI];
  logic [W-1:0]   alu_y_a [NI];
  logic [5:0]     alu_ctrl_a [NI];
  logic [W-1:0]   alu_out_a [NI];
  logic           alu_zr_a [NI];
  logic           alu_ng_a [NI];

  int n_pass = 0;
  int n_total = 0;

  // Hack ALU: returns {zr, ng, out}
  function automatic logic [W+1:0] hack_alu(input logic [W-1:0] x, input logic [W-1:0] y,
                                            input logic [5:0] c);
    logic [W-1:0] a, b, o;
    a = c[5] ? '0 : x;
    if (c[4]) a = ~a;
    b = c[3] ? '0 : y;
    if (c[2]) b = ~b;
    o = c[1] ? a + b : a & b;
    if (c[0]) o = ~o;
    return {(o == '0), o[W-1], o};
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
  endfunction

  genvar gi;
  for (gi = 0; gi < NI; gi++) begin : g_dut
    alu_arbiter #(.W(W), .ALU_LAT(gi == 0 ? 1 : (gi == 1 ? 3 : 4))) dut (
      .clk      (clk),
      .reset    (reset),
      .req_valid(req_valid_a[gi]),
      .req_ready(req_ready_a[gi]),
      .req_x    (req_x),
      .req_y    (req_y),
      .req_ctrl (req_ctrl),
      .rsp_valid(rsp_valid_a[gi]),
      .rsp_ready(rsp_ready_a[gi]),
      .rsp_data (rsp_data_a[gi]),
      .rsp_zr   (rsp_zr_a[gi]),
      .rsp_ng   (rsp_ng_a[gi]),
      .alu_x    (alu_x_a[gi]),
      .alu_y    (alu_y_a[gi]),
      .alu_ctrl (alu_ctrl_a[gi]),
      .alu_out  (alu_out_a[gi]),
      .alu_zr   (alu_zr_a[gi]),
      .alu_ng   (alu_ng_a[gi]),
      .busy     (busy_a[gi])
    );
    assign {alu_zr_a[gi], alu_ng_a[gi], alu_out_a[gi]} =
      hack_alu(alu_x_a[gi], alu_y_a[gi], alu_ctrl_a[gi]);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic to_sample();
    @(negedge clk);
  endtask

  task automatic to_drive();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < NI; i++) begin
      req_valid_a[i] = 2'b00;
      rsp_ready_a[i] = 2'b00;
    end
  endtask

  task automatic check_zero(input int k, input string tag);
    check(tag, {req_ready_a[k], rsp_valid_a[k], busy_a[k], rsp_data_a[k], rsp_zr_a[k],
                rsp_ng_a[k], alu_x_a[k], alu_y_a[k], alu_ctrl_a[k]}, 64'd0);
  endtask

  // Called at a drive point; returns at a drive point with reset released.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    to_sample();
    for (int k = 0; k < NI; k++) check_zero(k, $sformatf("reset_state_i%0d", k));
    to_drive();
    reset = 1'b0;
  endtask

  task automatic drain(input int k);
    req_valid_a[k] = 2'b00;
    rsp_ready_a[k] = 2'b11;
    repeat (8) to_drive();
    rsp_ready_a[k] = 2'b00;
  endtask

  task automatic set_operands(input int r, input logic [W-1:0] x, input logic [W-1:0] y,
                              input logic [5:0] c);
    req_x = $urandom;
    req_y = $urandom;
    req_ctrl = 12'($urandom);
    req_x[r*W +: W] = x;
    req_y[r*W +: W] = y;
    req_ctrl[r*6 +: 6] = c;
  endtask

  // One isolated transaction on instance k from requester r, checked cycle by cycle.
  task automatic run_txn(input int k, input int r, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [5:0] c, input logic [W-1:0] d, input logic zr,
                         input logic ng, input string tag);
    int lat;
    logic [1:0] oh;
    lat = lat_of(k);
    oh = 2'(1 << r);
    set_operands(r, x, y, c);
    req_valid_a[k] = oh;
    rsp_ready_a[k] = oh;
    to_sample();
    check({tag, "_accept"}, {req_ready_a[k], busy_a[k]}, {oh, 1'b0});
    to_drive();
    req_valid_a[k] = 2'b00;
    set_operands(r, ~x, ~y, ~c);
    for (int i = 0; i < lat; i++) begin
      to_sample();
      check({tag, "_exec"}, {rsp_valid_a[k], req_ready_a[k], busy_a[k]}, {2'b00, 2'b00, 1'b1});
      check({tag, "_alu_in"}, {alu_x_a[k], alu_y_a[k], alu_ctrl_a[k]}, {x, y, c});
      to_drive();
    end
    to_sample();
    check({tag, "_rsp"}, {rsp_valid_a[k], rsp_data_a[k], rsp_zr_a[k], rsp_ng_a[k]},
          {oh, d, zr, ng});
    to_drive();
    rsp_ready_a[k] = 2'b00;
    to_sample();
    check({tag, "_idle"}, {rsp_valid_a[k], busy_a[k]}, 3'b000);
    to_drive();
  endtask

  typedef struct packed {
    logic [1:0]   k;
    logic         r;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [5:0]   c;
    logic [W-1:0] d;
    logic         zr;
    logic         ng;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int gcnt, gcyc[4], gidx[4], exp_g;
    logic [W-1:0] held;

    vecs[0] = '{2'd0, 1'b0, 16'd5,      16'd3,      6'b000010, 16'd8,      1'b0, 1'b0};
    vecs[1] = '{2'd0, 1'b0, 16'd3,      16'd5,      6'b010011, 16'hFFFE,   1'b0, 1'b1};
    vecs[2] = '{2'd0, 1'b0, 16'd3,      16'd5,      6'b101010, 16'd0,      1'b1, 1'b0};
    vecs[3] = '{2'd0, 1'b1, 16'hFFFF,   16'h0001,   6'b000010, 16'd0,      1'b1, 1'b0};
    vecs[4] = '{2'd1, 1'b1, 16'h1234,   16'h00FF,   6'b000000, 16'h0034,   1'b0, 1'b0};
    vecs[5] = '{2'd1, 1'b0, 16'h8000,   16'h0000,   6'b000010, 16'h8000,   1'b0, 1'b1};
    vecs[6] = '{2'd2, 1'b0, 16'd7,      16'd9,      6'b000111, 16'd2,      1'b0, 1'b0};
    vecs[7] = '{2'd2, 1'b1, 16'hAAAA,   16'h5555,   6'b000001, 16'hFFFF,   1'b0, 1'b1};

    clear_inputs();
    req_x = '0;
    req_y = '0;
    req_ctrl = '0;
    reset = 1'b1;
    to_drive();
    do_reset();

    for (int i = 0; i < 8; i++) begin
      run_txn(int'(vecs[i].k), int'(vecs[i].r), vecs[i].x, vecs[i].y, vecs[i].c,
              vecs[i].d, vecs[i].zr, vecs[i].ng, $sformatf("vec%0d", i));
    end

    // Contention on the ALU_LAT=1 instance: both requesters held, responses always accepted.
    do_reset();
    set_operands(0, 16'd1, 16'd2, 6'b000010);
    req_valid_a[0] = 2'b11;
    rsp_ready_a[0] = 2'b11;
    gcnt = 0;
    for (int c = 0; c < 40 && gcnt < 4; c++) begin
      to_sample();
      if (req_ready_a[0] != 2'b00) begin
        gidx[gcnt] = int'(req_ready_a[0][1]);
        gcyc[gcnt] = c;
        check("contention_onehot", 64'($countones(req_ready_a[0])), 64'd1);
        gcnt++;
      end
      if (gcnt < 4) to_drive();
    end
    check("contention_grant_count", 64'(gcnt), 64'd4);
    for (int i = 0; i < gcnt; i++) begin
`ifdef ALU_ARBITER_RR_EN
      exp_g = i % 2;
`else
      exp_g = 0;
`endif
      check($sformatf("contention_grant%0d", i), 64'(gidx[i]), 64'(exp_g));
      if (i > 0) check($sformatf("contention_gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'd3);
    end
    to_drive();
    drain(0);

    // Backpressure: response held while the other requester waits and its rsp_ready is ignored.
    do_reset();
    set_operands(0, 16'h0102, 16'h0304, 6'b000010);
    req_valid_a[0] = 2'b01;
    to_sample();
    check("bp_accept", req_ready_a[0], 2'b01);
    to_drive();
    req_valid_a[0] = 2'b10;
    to_sample();
    check("bp_exec", {req_ready_a[0], busy_a[0]}, 3'b001);
    to_drive();
    rsp_ready_a[0] = 2'b10;
    for (int c = 0; c < 5; c++) begin
      to_sample();
      check($sformatf("bp_hold%0d", c),
            {rsp_valid_a[0], rsp_data_a[0], busy_a[0], req_ready_a[0]},
            {2'b01, 16'h0406, 1'b1, 2'b00});
      to_drive();
    end
    rsp_ready_a[0] = 2'b01;
    to_sample();
    check("bp_release", rsp_valid_a[0], 2'b01);
    to_drive();
    rsp_ready_a[0] = 2'b00;
    to_sample();
    check("bp_pending_granted", {req_ready_a[0], busy_a[0]}, 3'b100);
    to_drive();
    drain(0);

    // Reset in the second EXEC cycle of the ALU_LAT=4 instance.
    do_reset();
    set_operands(0, 16'h0F0F, 16'h0101, 6'b000010);
    req_valid_a[2] = 2'b01;
    rsp_ready_a[2] = 2'b01;
    to_sample();
    check("rst_accept", req_ready_a[2], 2'b01);
    to_drive();
    req_valid_a[2] = 2'b00;
    to_sample();
    check("rst_exec1", busy_a[2], 1'b1);
    to_drive();
    reset = 1'b1;
    #1;
    check_zero(2, "rst_mid_exec_outputs");
    to_sample();
    to_drive();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      to_sample();
      check($sformatf("rst_no_rsp%0d", c), {rsp_valid_a[2], busy_a[2]}, 3'b000);
      to_drive();
    end
    rsp_ready_a[2] = 2'b00;
    run_txn(2, 0, 16'h0F0F, 16'h0101, 6'b000010, 16'h1010, 1'b0, 1'b0, "rst_after");

    // Throughput on the ALU_LAT=3 instance: accept every ALU_LAT+2 cycles.
    do_reset();
    set_operands(0, 16'd4, 16'd4, 6'b000010);
    req_valid_a[1] = 2'b01;
    rsp_ready_a[1] = 2'b01;
    gcnt = 0;
    for (int c = 0; c < 40 && gcnt < 4; c++) begin
      to_sample();
      if (req_ready_a[1] != 2'b00) begin
        gcyc[gcnt] = c;
        gcnt++;
      end
      if (gcnt < 4) to_drive();
    end
    check("tput_pulse_count", 64'(gcnt), 64'd4);
    for (int i = 1; i < gcnt; i++)
      check($sformatf("tput_gap%0d", i), 64'(gcyc[i] - gcyc[i-1]), 64'd5);
    to_drive();
    drain(1);

    // Randomized traffic against a transaction-level model on each instance.
    for (int k = 0; k < NI; k++) begin
      logic         m_busy, m_owner, m_zr, m_ng, m_last, win;
      logic [W-1:0] m_data;
      logic [W+1:0] res;
      logic [1:0]   e_rr, e_rv, rv;
      int           m_avail;
      do_reset();
      m_busy = 1'b0;
      m_owner = 1'b0;
      m_last = 1'b1;
      m_avail = 0;
      m_data = '0;
      m_zr = 1'b0;
      m_ng = 1'b0;
      for (int cyc = 0; cyc < 250; cyc++) begin
        req_valid_a[k] = 2'($urandom_range(0, 3));
        rsp_ready_a[k] = 2'($urandom_range(0, 3));
        req_x = $urandom;
        req_y = $urandom;
        req_ctrl = 12'($urandom);
        to_sample();
        rv = req_valid_a[k];
`ifdef ALU_ARBITER_RR_EN
        win = (rv == 2'b11) ? ~m_last : ~rv[0];
`else
        win = ~rv[0];
`endif
        e_rr = (!m_busy && rv != 2'b00) ? 2'(1 << win) : 2'b00;
        e_rv = (m_busy && cyc >= m_avail) ? 2'(1 << m_owner) : 2'b00;
        check($sformatf("rand_i%0d_c%0d_ctl", k, cyc),
              {req_ready_a[k], rsp_valid_a[k], busy_a[k]}, {e_rr, e_rv, m_busy});
        if (e_rv != 2'b00)
          check($sformatf("rand_i%0d_c%0d_data", k, cyc),
                {rsp_data_a[k], rsp_zr_a[k], rsp_ng_a[k]}, {m_data, m_zr, m_ng});
        if (!m_busy && rv != 2'b00) begin
          res = hack_alu(req_x[int'(win)*W +: W], req_y[int'(win)*W +: W],
                         req_ctrl[int'(win)*6 +: 6]);
          {m_zr, m_ng, m_data} = res;
          m_busy = 1'b1;
          m_owner = win;
          m_last = win;
          m_avail = cyc + lat_of(k) + 1;
        end else if (m_busy && cyc >= m_avail && rsp_ready_a[k][m_owner]) begin
          m_busy = 1'b0;
        end
        to_drive();
      end
      req_valid_a[k] = 2'b00;
      rsp_ready_a[k] = 2'b00;
    end

    held = '0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter W, default 16: operand/result width.
REQ-002 Parameter ALU_LAT, default 1: cycles from operands driven to result sampled; legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  2  request valid; bit i = requester i.
REQ-006 req_ready  output  2  accept strobe; at most one bit high.
REQ-007 req_x  input  2*W  operand x; requester i in bits [i*W +: W].
REQ-008 req_y  input  2*W  operand y; same packing.
REQ-009 req_ctrl  input  12  Hack ALU control {zx,nx,zy,ny,f,no}; requester i in bits [i*6 +: 6].
REQ-010 rsp_valid  output  2  result valid; at most one bit high.
REQ-011 rsp_ready  input  2  per-requester result accept.
REQ-012 rsp_data  output  W  registered ALU result.
REQ-013 rsp_zr, rsp_ng  output  1 each  registered zero and negative flags.
REQ-014 alu_x, alu_y  output  W each; alu_ctrl  output  6; all drive the shared combinational ALU.
REQ-015 alu_out  input  W; alu_zr, alu_ng  input  1 each; all driven by the shared ALU.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-018 In IDLE with any req_valid bit high: grant one requester g, assert req_ready[g] combinationally for that cycle, capture req_x/req_y/req_ctrl of g at the edge, then enter EXEC.
REQ-019 req_ready SHALL never be asserted outside IDLE.
REQ-020 alu_x, alu_y and alu_ctrl SHALL always drive the captured operand registers.
REQ-021 EXEC SHALL last exactly ALU_LAT cycles; on its final edge, latch alu_out, alu_zr and alu_ng into rsp_data, rsp_zr and rsp_ng, then enter RESP.
REQ-022 In RESP, rsp_valid[g] SHALL be 1 and rsp_data/rsp_zr/rsp_ng stable until an edge with rsp_ready[g]=1, then the FSM returns to IDLE; rsp_ready of the non-granted bit SHALL be ignored.
REQ-023 Latency: accept at edge n gives rsp_valid[g] high in the cycle after edge n+ALU_LAT; with rsp_ready held high, the minimum accept-to-accept interval is ALU_LAT+2 cycles.
REQ-024 A pending requester not granted SHALL stay pending; it is never dropped while its req_valid remains high.
REQ-025 req_valid deasserted before grant SHALL cause no action.
REQ-026 Data SHALL pass through without width change, truncation or sign extension.

Reset
REQ-027 reset high SHALL immediately force: IDLE; req_ready, rsp_valid and busy = 0; rsp_data, rsp_zr and rsp_ng = 0; operand registers, alu_x, alu_y and alu_ctrl = 0; EXEC counter = 0; priority pointer = 0.
REQ-028 Reset during EXEC or RESP SHALL discard the in-flight operation; no rsp_valid for it after release.
REQ-029 The first edge after reset release SHALL behave as IDLE.

Configuration
REQ-030 With macro ALU_ARBITER_RR_EN defined: round-robin arbitration. Pointer p (reset 0) selects the winner when both requesters are valid; after every grant, p becomes the requester other than g; a lone request is granted regardless of p.
REQ-031 With ALU_ARBITER_RR_EN undefined: fixed priority, requester 0 always wins; no pointer register exists.

Verification
REQ-032 Single add: req 0, x=5, y=3, ctrl=000010, ALU_LAT=1, behavioural Hack ALU -> req_ready[0] pulse in cycle 0, rsp_valid[0] in cycle 2, rsp_data=8, zr=0, ng=0.
REQ-033 Subtract and zero: x=3, y=5, ctrl=010011 -> rsp_data=16'hFFFE, ng=1; ctrl=101010 -> rsp_data=0, zr=1.
REQ-034 Contention: both req_valid held, 4 ops, rsp_ready high -> grants 0,1,0,1 with ALU_ARBITER_RR_EN defined; grants 0,0,0,0 with it undefined.
REQ-035 Backpressure: rsp_ready[0] low for 5 cycles while req_valid[1]=1 -> rsp_valid[0], rsp_data and busy=1 stable; req_ready stays 00.
REQ-036 Reset mid-EXEC, ALU_LAT=4, reset high in the second EXEC cycle -> all outputs 0 at once; no rsp_valid after release; the next request completes correctly.
REQ-037 Throughput: ALU_LAT=3, req_valid[0] and rsp_ready[0] held high -> req_ready[0] pulses every 5 cycles.
